// File: rtl/input_block_buffer_if.sv
`default_nettype none
// ============================================================================
// Module   : input_block_buffer_if
// Purpose  : Raster-in / 8x2-block-out bus bundle for input_block_buffer.
// Revision : 1.0
// ============================================================================
interface input_block_buffer_if #(
    parameter int MAX_SLICE_WIDTH = 2560
) ();
    localparam int SW_W = $clog2(MAX_SLICE_WIDTH);

    logic                    sof;
    logic [SW_W-1:0]         slice_width;
    logic                    in_valid;
    logic [4*3*14-1:0]       in_data_p;
    logic                    blk_valid;
    logic [2*8*3*14-1:0]     blk_p;
    logic                    blk_sof;

    modport master (
        output sof, slice_width, in_valid, in_data_p,
        input  blk_valid, blk_p, blk_sof
    );

    modport slave (
        input  sof, slice_width, in_valid, in_data_p,
        output blk_valid, blk_p, blk_sof
    );
endinterface
`default_nettype wire

// File: rtl/input_block_buffer.sv
`default_nettype none
// ============================================================================
// Module   : input_block_buffer
// Purpose  : Buffers even raster rows and pairs them with odd rows into 8x2
//            three-component blocks (cscBlk_p packing).
// Revision : 1.0
// ============================================================================
module input_block_buffer #(
    parameter int MAX_SLICE_WIDTH = 2560
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    input_block_buffer_if.slave bus
);
    localparam int PIX_W  = 14;
    localparam int PXL_W  = 3 * PIX_W;
    localparam int WORD_W = 4 * PXL_W;
    localparam int BLK_W  = 2 * 8 * 3 * PIX_W;
    localparam int DEPTH  = MAX_SLICE_WIDTH / 4;
    localparam int AW     = $clog2(DEPTH);
    localparam int SW_W   = $clog2(MAX_SLICE_WIDTH);

    logic [WORD_W-1:0] line_mem [DEPTH];
    logic [WORD_W-1:0] rd_data_q;

    logic [AW-1:0]     wc_q, wc_d, cur_wc;
    logic              odd_q, odd_d, cur_odd;
    logic              first_q, first_d;
    logic              s1_valid_q, s1_valid_d;
    logic              s1_hi_q, s1_hi_d;
    logic              s1_done_q, s1_done_d;
    logic [WORD_W-1:0] odd_dly_q, odd_dly_d;
    logic [WORD_W-1:0] even_lo_q, even_lo_d;
    logic [WORD_W-1:0] odd_lo_q, odd_lo_d;
    logic              blk_valid_q, blk_valid_d;
    logic              blk_sof_q, blk_sof_d;
    logic [BLK_W-1:0]  blk_p_q, blk_p_d, blk_asm;
    logic [SW_W-1:0]   nw_m1;
    logic              last_word, mem_we, mem_re;
    logic [WORD_W-1:0] lo_e, lo_o, hi_e, hi_o;

    // sof restarts the position in the same cycle, so its word lands at word 0
    assign cur_wc    = bus.sof ? '0 : wc_q;
    assign cur_odd   = bus.sof ? 1'b0 : odd_q;
    assign nw_m1     = (bus.slice_width >> 2) - SW_W'(1);
    assign last_word = (SW_W'(cur_wc) == nw_m1);

    always_comb begin
        if (s1_hi_q) begin
            lo_e = even_lo_q;
            lo_o = odd_lo_q;
            hi_e = rd_data_q;
            hi_o = odd_dly_q;
        end else begin
            // Short final block: right half repeats the rightmost real pixel
            lo_e = rd_data_q;
            lo_o = odd_dly_q;
            hi_e = {4{rd_data_q[3*PXL_W +: PXL_W]}};
            hi_o = {4{odd_dly_q[3*PXL_W +: PXL_W]}};
        end
        blk_asm = '0;
        for (int cp = 0; cp < 3; cp++) begin
            for (int col = 0; col < 4; col++) begin
                blk_asm[(cp*16 + col)*PIX_W      +: PIX_W] = lo_e[(col*3 + cp)*PIX_W +: PIX_W];
                blk_asm[(cp*16 + 8 + col)*PIX_W  +: PIX_W] = lo_o[(col*3 + cp)*PIX_W +: PIX_W];
                blk_asm[(cp*16 + 4 + col)*PIX_W  +: PIX_W] = hi_e[(col*3 + cp)*PIX_W +: PIX_W];
                blk_asm[(cp*16 + 12 + col)*PIX_W +: PIX_W] = hi_o[(col*3 + cp)*PIX_W +: PIX_W];
            end
        end
    end

    always_comb begin
        wc_d        = wc_q;
        odd_d       = odd_q;
        first_d     = first_q;
        s1_valid_d  = 1'b0;
        s1_hi_d     = s1_hi_q;
        s1_done_d   = s1_done_q;
        odd_dly_d   = odd_dly_q;
        even_lo_d   = even_lo_q;
        odd_lo_d    = odd_lo_q;
        blk_valid_d = 1'b0;
        blk_sof_d   = 1'b0;
        blk_p_d     = blk_p_q;
        mem_we      = 1'b0;
        mem_re      = 1'b0;

        if (bus.sof) begin
            wc_d    = '0;
            odd_d   = 1'b0;
            first_d = 1'b1;
        end

        if (bus.in_valid) begin
            if (!cur_odd) begin
                mem_we = 1'b1;
            end else begin
                mem_re     = 1'b1;
                s1_valid_d = 1'b1;
                s1_hi_d    = cur_wc[0];
                s1_done_d  = cur_wc[0] | last_word;
                odd_dly_d  = bus.in_data_p;
            end
            if (last_word) begin
                wc_d  = '0;
                odd_d = ~cur_odd;
            end else begin
                wc_d = cur_wc + AW'(1);
            end
        end

        if (s1_valid_q && !bus.sof) begin
            if (!s1_hi_q) begin
                even_lo_d = rd_data_q;
                odd_lo_d  = odd_dly_q;
            end
            if (s1_done_q) begin
                blk_valid_d = 1'b1;
                blk_sof_d   = first_q;
                first_d     = 1'b0;
                blk_p_d     = blk_asm;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) line_mem[cur_wc] <= bus.in_data_p;
        if (mem_re) rd_data_q <= line_mem[cur_wc];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wc_q        <= '0;
            odd_q       <= 1'b0;
            first_q     <= 1'b1;
            s1_valid_q  <= 1'b0;
            s1_hi_q     <= 1'b0;
            s1_done_q   <= 1'b0;
            odd_dly_q   <= '0;
            even_lo_q   <= '0;
            odd_lo_q    <= '0;
            blk_valid_q <= 1'b0;
            blk_sof_q   <= 1'b0;
            blk_p_q     <= '0;
        end else begin
            wc_q        <= wc_d;
            odd_q       <= odd_d;
            first_q     <= first_d;
            s1_valid_q  <= s1_valid_d;
            s1_hi_q     <= s1_hi_d;
            s1_done_q   <= s1_done_d;
            odd_dly_q   <= odd_dly_d;
            even_lo_q   <= even_lo_d;
            odd_lo_q    <= odd_lo_d;
            blk_valid_q <= blk_valid_d;
            blk_sof_q   <= blk_sof_d;
            blk_p_q     <= blk_p_d;
        end
    end

    assign bus.blk_valid = blk_valid_q;
    assign bus.blk_sof   = blk_sof_q;
    assign bus.blk_p     = blk_p_q;

endmodule
`default_nettype wire
